// File: rtl/rtc_bus_sequencer_pkg.sv
// Shared RTC bus sequencer types: command codes, FSM states, strobe windows.
// Latency: n/a (types and constants only); backpressure: n/a.
package rtc_bus_sequencer_pkg;

    typedef enum logic [1:0] {
        CMD_INIT = 2'd0,
        CMD_LEC  = 2'd1,
        CMD_ESC  = 2'd2,
        CMD_MOD  = 2'd3
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Inclusive cont_32 windows for each active-low strobe.
    localparam logic [4:0] CS_LO      = 5'd2;
    localparam logic [4:0] CS_HI      = 5'd29;
    localparam logic [4:0] AD_LO      = 5'd2;
    localparam logic [4:0] AD_HI      = 5'd9;
    localparam logic [4:0] WR_ADDR_LO = 5'd4;
    localparam logic [4:0] WR_ADDR_HI = 5'd8;
    localparam logic [4:0] WR_DATA_LO = 5'd16;
    localparam logic [4:0] WR_DATA_HI = 5'd22;
    localparam logic [4:0] RD_LO      = 5'd20;
    localparam logic [4:0] RD_HI      = 5'd28;

    localparam logic [4:0] RD_FIRST_FRAME = 5'd7;
    localparam logic [4:0] LE_FIRST_FRAME = 5'd8;

    function automatic logic in_win(input logic [4:0] c, input logic [4:0] lo,
                                    input logic [4:0] hi);
        return (c >= lo) && (c <= hi);
    endfunction

    // A write burst turns into read-back once it reaches the first read frame.
    function automatic logic is_read_frame(input logic [1:0] cmd, input logic [4:0] frame);
        return (cmd == CMD_LEC) || ((cmd == CMD_ESC) && (frame >= RD_FIRST_FRAME));
    endfunction

endpackage

// File: rtl/rtc_bus_sequencer_strobe_gen.sv
// Registered decode of the next frame position into the four RTC bus strobes.
// Latency: 1 cycle (fed with next-state values so strobes align with cont_32); no backpressure.
module rtc_strobe_gen
    import rtc_bus_sequencer_pkg::*;
(
    input  logic       reloj,
    input  logic       resetM,
    input  logic [4:0] cnt,
    input  logic       rd_frame,
    input  logic       run,
    output logic       CS_n,
    output logic       AD_n,
    output logic       RD_n,
    output logic       WR_n
);

    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            CS_n <= 1'b1;
            AD_n <= 1'b1;
            RD_n <= 1'b1;
            WR_n <= 1'b1;
        end else if (!run) begin
            CS_n <= 1'b1;
            AD_n <= 1'b1;
            RD_n <= 1'b1;
            WR_n <= 1'b1;
        end else begin
            CS_n <= !in_win(cnt, CS_LO, CS_HI);
            AD_n <= !in_win(cnt, AD_LO, AD_HI);
            RD_n <= !(rd_frame && in_win(cnt, RD_LO, RD_HI));
            WR_n <= !(in_win(cnt, WR_ADDR_LO, WR_ADDR_HI) ||
                      (!rd_frame && in_win(cnt, WR_DATA_LO, WR_DATA_HI)));
        end
    end

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Sequences RTC mux-bus bursts from a PicoBlaze start command and frames the mux/demux.
// Latency: sync 1 cycle after the start write, busy for 1+32*len+1 cycles; starts while busy are dropped.
module rtc_bus_sequencer
    import rtc_bus_sequencer_pkg::*;
#(
    parameter logic [7:0] PUERTO_CMD = 8'h11,
    parameter int         N_LEC      = 10,
    parameter int         N_ESC      = 17,
    parameter int         N_UNI      = 1
) (
    input  logic       reloj,
    input  logic       resetM,
    input  logic       en_01,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    output logic [7:0] estado,
    output logic [4:0] cont_32,
    output logic       enable_cont_32,
    output logic [4:0] cont17,
    output logic       LE,
    output logic       sync,
    output logic       CS_n,
    output logic       AD_n,
    output logic       RD_n,
    output logic       WR_n
);

    state_t     state, state_nxt;
    logic [1:0] cmd_q, cmd_nxt;
    logic [4:0] c32_nxt, c17_nxt, last_frame;
    logic       busy, done_flag, start;
    logic       unused_out_port;

    assign unused_out_port = ^out_port[7:2];
    assign start  = en_01 && (port_id == PUERTO_CMD);
    assign estado = {6'b0, done_flag, busy};

    always_comb begin
        case (cmd_q)
            CMD_LEC: last_frame = 5'(N_LEC - 1);
            CMD_ESC: last_frame = 5'(N_ESC - 1);
            default: last_frame = 5'(N_UNI - 1);
        endcase
    end

    always_comb begin
        state_nxt = state;
        cmd_nxt   = cmd_q;
        c32_nxt   = cont_32;
        c17_nxt   = cont17;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_SYNC;
                    cmd_nxt   = out_port[1:0];
                end
            end
            ST_SYNC: begin
                state_nxt = ST_RUN;
                c32_nxt   = 5'd0;
                c17_nxt   = 5'd0;
            end
            ST_RUN: begin
                c32_nxt = cont_32 + 5'd1;
                if (cont_32 == 5'd31) begin
                    if (cont17 == last_frame) begin
                        state_nxt = ST_DONE;
                        c17_nxt   = 5'd0;
                    end else begin
                        c17_nxt = cont17 + 5'd1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                c32_nxt   = 5'd0;
                c17_nxt   = 5'd0;
            end
        endcase
    end

    // Flags are registered from next-state values so they line up with the counters.
    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            state          <= ST_IDLE;
            cmd_q          <= 2'd0;
            cont_32        <= 5'd0;
            cont17         <= 5'd0;
            sync           <= 1'b0;
            enable_cont_32 <= 1'b0;
            LE             <= 1'b0;
            busy           <= 1'b0;
            done_flag      <= 1'b0;
        end else begin
            state          <= state_nxt;
            cmd_q          <= cmd_nxt;
            cont_32        <= c32_nxt;
            cont17         <= c17_nxt;
            sync           <= (state_nxt == ST_SYNC);
            enable_cont_32 <= (state_nxt == ST_RUN) && (c32_nxt == 5'd31);
            LE             <= (state_nxt == ST_RUN) && (cmd_nxt == CMD_ESC) &&
                              (c17_nxt >= LE_FIRST_FRAME);
            if (state == ST_IDLE && start) begin
                busy      <= 1'b1;
                done_flag <= 1'b0;
            end else if (state == ST_DONE) begin
                busy      <= 1'b0;
                done_flag <= 1'b1;
            end
        end
    end

    rtc_strobe_gen u_strobe (
        .reloj    (reloj),
        .resetM   (resetM),
        .cnt      (c32_nxt),
        .rd_frame (is_read_frame(cmd_nxt, c17_nxt)),
        .run      (state_nxt == ST_RUN),
        .CS_n     (CS_n),
        .AD_n     (AD_n),
        .RD_n     (RD_n),
        .WR_n     (WR_n)
    );

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer: bursts of each command, ignored starts, async reset.
module tb_rtc_bus_sequencer;

    logic       reloj = 1'b0;
    logic       resetM;
    logic       en_01;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic [7:0] estado;
    logic [4:0] cont_32;
    logic       enable_cont_32;
    logic [4:0] cont17;
    logic       LE;
    logic       sync;
    logic       CS_n, AD_n, RD_n, WR_n;

    int checks   = 0;
    int failures = 0;

    always #5 reloj = ~reloj;

    rtc_bus_sequencer dut (
        .reloj          (reloj),
        .resetM         (resetM),
        .en_01          (en_01),
        .port_id        (port_id),
        .out_port       (out_port),
        .estado         (estado),
        .cont_32        (cont_32),
        .enable_cont_32 (enable_cont_32),
        .cont17         (cont17),
        .LE             (LE),
        .sync           (sync),
        .CS_n           (CS_n),
        .AD_n           (AD_n),
        .RD_n           (RD_n),
        .WR_n           (WR_n)
    );

    task automatic do_write(input logic [7:0] p, input logic [7:0] d);
        @(negedge reloj);
        en_01    = 1'b1;
        port_id  = p;
        out_port = d;
        @(negedge reloj);
        en_01    = 1'b0;
        port_id  = 8'h00;
        out_port = 8'h00;
    endtask

    task automatic test_reset;
        resetM   = 1'b0;
        en_01    = 1'b0;
        port_id  = 8'h00;
        out_port = 8'h00;
        repeat (3) @(negedge reloj);
        checks++;
        if ({CS_n, AD_n, WR_n, RD_n} !== 4'b1111 || estado !== 8'h00 || sync !== 1'b0 ||
            enable_cont_32 !== 1'b0 || LE !== 1'b0 || cont_32 !== 5'd0 || cont17 !== 5'd0) begin
            failures++;
            $display("FAIL reset_state: strobes=%b estado=%h sync=%b en=%b LE=%b c32=%0d c17=%0d, want 1111/00/0/0/0/0/0",
                     {CS_n, AD_n, WR_n, RD_n}, estado, sync, enable_cont_32, LE, cont_32, cont17);
        end
        resetM = 1'b1;
        repeat (2) @(negedge reloj);
        checks++;
        if (estado !== 8'h00 || sync !== 1'b0 || CS_n !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_idle: estado=%h sync=%b CS_n=%b, want 00/0/1", estado, sync, CS_n);
        end
    endtask

    // Cycle-by-cycle model of one full burst starting from IDLE.
    task automatic check_burst(input logic [7:0] cmd, input int nframes, input bit inject,
                               input string nm);
        logic [1:0] c;
        bit         rdf;
        int         cyc, fr, pulses, last_pulse;
        logic       e_cs, e_ad, e_wr, e_rd, e_le, e_en;
        c = cmd[1:0];
        pulses = 0;
        last_pulse = -1;
        do_write(8'h11, cmd);
        checks++;
        if (sync !== 1'b1 || estado !== 8'h01 || cont_32 !== 5'd0 || cont17 !== 5'd0 ||
            {CS_n, AD_n, WR_n, RD_n} !== 4'b1111) begin
            failures++;
            $display("FAIL %s sync_cycle: sync=%b estado=%h c32=%0d c17=%0d strobes=%b, want 1/01/0/0/1111",
                     nm, sync, estado, cont_32, cont17, {CS_n, AD_n, WR_n, RD_n});
        end
        for (int k = 0; k < 32 * nframes; k++) begin
            @(negedge reloj);
            cyc  = k % 32;
            fr   = k / 32;
            rdf  = (c == 2'd1) || (c == 2'd2 && fr >= 7);
            e_cs = !(cyc >= 2 && cyc <= 29);
            e_ad = !(cyc >= 2 && cyc <= 9);
            e_wr = !((cyc >= 4 && cyc <= 8) || (!rdf && cyc >= 16 && cyc <= 22));
            e_rd = !(rdf && cyc >= 20 && cyc <= 28);
            e_le = (c == 2'd2) && (fr >= 8);
            e_en = (cyc == 31);
            checks++;
            if (cont_32 !== 5'(cyc) || cont17 !== 5'(fr)) begin
                failures++;
                $display("FAIL %s counters k=%0d: c32=%0d c17=%0d, want %0d/%0d",
                         nm, k, cont_32, cont17, cyc, fr);
            end
            checks++;
            if ({CS_n, AD_n, WR_n, RD_n} !== {e_cs, e_ad, e_wr, e_rd}) begin
                failures++;
                $display("FAIL %s strobes frame=%0d cyc=%0d: CS/AD/WR/RD=%b, want %b",
                         nm, fr, cyc, {CS_n, AD_n, WR_n, RD_n}, {e_cs, e_ad, e_wr, e_rd});
            end
            checks++;
            if (sync !== 1'b0 || enable_cont_32 !== e_en || LE !== e_le || estado !== 8'h01) begin
                failures++;
                $display("FAIL %s flags frame=%0d cyc=%0d: sync=%b en=%b LE=%b estado=%h, want 0/%b/%b/01",
                         nm, fr, cyc, sync, enable_cont_32, LE, estado, e_en, e_le);
            end
            if (enable_cont_32 === 1'b1) begin
                if (last_pulse >= 0) begin
                    checks++;
                    if (k - last_pulse != 32) begin
                        failures++;
                        $display("FAIL %s pulse_spacing: got %0d, want 32", nm, k - last_pulse);
                    end
                end
                last_pulse = k;
                pulses++;
            end
            if (inject && k == 50) begin
                en_01 = 1'b1; port_id = 8'h11; out_port = 8'h03;
            end else if (inject && k == 51) begin
                en_01 = 1'b0; port_id = 8'h00; out_port = 8'h00;
            end
        end
        checks++;
        if (pulses != nframes) begin
            failures++;
            $display("FAIL %s pulse_count: got %0d, want %0d", nm, pulses, nframes);
        end
        @(negedge reloj);
        checks++;
        if (estado !== 8'h01 || {CS_n, AD_n, WR_n, RD_n} !== 4'b1111 || LE !== 1'b0 ||
            enable_cont_32 !== 1'b0 || cont_32 !== 5'd0 || cont17 !== 5'd0) begin
            failures++;
            $display("FAIL %s done_cycle: estado=%h strobes=%b LE=%b en=%b c32=%0d c17=%0d, want 01/1111/0/0/0/0",
                     nm, estado, {CS_n, AD_n, WR_n, RD_n}, LE, enable_cont_32, cont_32, cont17);
        end
        @(negedge reloj);
        checks++;
        if (estado !== 8'h02 || sync !== 1'b0 || {CS_n, AD_n, WR_n, RD_n} !== 4'b1111) begin
            failures++;
            $display("FAIL %s after_done: estado=%h sync=%b strobes=%b, want 02/0/1111",
                     nm, estado, sync, {CS_n, AD_n, WR_n, RD_n});
        end
    endtask

    task automatic test_read;
        check_burst(8'h01, 10, 1'b0, "read");
    endtask

    task automatic test_write_burst;
        check_burst(8'h02, 17, 1'b0, "esc");
    endtask

    task automatic test_busy_ignore;
        check_burst(8'h01, 10, 1'b1, "busy_ignore");
    endtask

    task automatic test_init;
        check_burst(8'h00, 1, 1'b0, "init");
        repeat (5) @(negedge reloj);
        checks++;
        if (estado !== 8'h02) begin
            failures++;
            $display("FAIL init_done_hold: estado=%h, want 02", estado);
        end
    endtask

    task automatic test_mod;
        check_burst(8'h03, 1, 1'b0, "mod");
    endtask

    task automatic test_port_miss;
        do_write(8'h10, 8'h01);
        repeat (3) @(negedge reloj);
        checks++;
        if (estado !== 8'h02 || sync !== 1'b0 || CS_n !== 1'b1 || cont_32 !== 5'd0) begin
            failures++;
            $display("FAIL port_miss: estado=%h sync=%b CS_n=%b c32=%0d, want 02/0/1/0",
                     estado, sync, CS_n, cont_32);
        end
    endtask

    task automatic test_reset_mid_run;
        bit found;
        found = 1'b0;
        do_write(8'h11, 8'h00);
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge reloj);
            if (cont_32 === 5'd22) found = 1'b1;
        end
        checks++;
        if (!found || WR_n !== 1'b0 || CS_n !== 1'b0) begin
            failures++;
            $display("FAIL mid_run_reach: found=%b WR_n=%b CS_n=%b, want 1/0/0", found, WR_n, CS_n);
        end
        #1 resetM = 1'b0;
        #1;
        checks++;
        if ({CS_n, AD_n, WR_n, RD_n} !== 4'b1111 || estado !== 8'h00 || cont_32 !== 5'd0) begin
            failures++;
            $display("FAIL async_reset: strobes=%b estado=%h c32=%0d, want 1111/00/0",
                     {CS_n, AD_n, WR_n, RD_n}, estado, cont_32);
        end
        @(negedge reloj);
        resetM = 1'b1;
        repeat (4) @(negedge reloj);
        checks++;
        if (estado !== 8'h00 || sync !== 1'b0 || {CS_n, AD_n, WR_n, RD_n} !== 4'b1111 ||
            cont_32 !== 5'd0 || cont17 !== 5'd0) begin
            failures++;
            $display("FAIL reset_idle_after: estado=%h sync=%b strobes=%b c32=%0d c17=%0d, want 00/0/1111/0/0",
                     estado, sync, {CS_n, AD_n, WR_n, RD_n}, cont_32, cont17);
        end
    endtask

    initial begin
        test_reset;
        test_read;
        test_write_burst;
        test_busy_ignore;
        test_init;
        test_port_miss;
        test_mod;
        test_reset_mid_run;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rtc_bus_sequencer.md
Name: rtc_bus_sequencer

Overview:
- Sequences transactions on the multiplexed address/data bus to the RTC.
- Decodes a start command from the PicoBlaze out_port and generates the RTC bus strobes (CS_n, AD_n, RD_n, WR_n).
- Generates the framing signals that drive the bus mux/demux block: cont_32, enable_cont_32, cont17, LE, sync.
- Reports busy/done status back to the PicoBlaze in_port.

Parameters:
PUERTO_CMD, 8'h11, port_id that carries the start command.
N_LEC, 10, number of frames in a READ burst.
N_ESC, 17, number of frames in a WRITE burst.
N_UNI, 1, number of frames for INIT (cmd 0) and MOD (cmd 3).

Ports:
reloj  in  1  system clock, all logic on rising edge.
resetM  in  1  asynchronous, active-low reset.
en_01  in  1  PicoBlaze write strobe.
port_id  in  8  PicoBlaze port address.
out_port  in  8  PicoBlaze data; bits [1:0] carry the command.
estado  out  8  status: {6'b0, done_flag, busy}.
cont_32  out  5  cycle index within a frame, 0..31.
enable_cont_32  out  1  one-cycle pulse on the last cycle of each frame.
cont17  out  5  frame index within the burst.
LE  out  1  read-back latch enable (WRITE bursts only).
sync  out  1  one-cycle burst-start pulse.
CS_n  out  1  RTC chip select, active-low.
AD_n  out  1  RTC address strobe, active-low.
RD_n  out  1  RTC read strobe, active-low.
WR_n  out  1  RTC write strobe, active-low.

Behaviour:
- Reset (resetM=0, asynchronous): state=IDLE, cmd_q=0, counters=0, sync=0, enable_cont_32=0, LE=0, busy=0, done_flag=0, all strobes=1. Strobes must deassert immediately, including mid-frame.
- Start: en_01=1 && port_id==PUERTO_CMD while IDLE -> cmd_q<=out_port[1:0], done_flag<=0, go to SYNC.
  - A start received in any non-IDLE state is ignored; cmd_q is unchanged.
- Burst length: cmd 1 -> N_LEC; cmd 2 -> N_ESC; cmd 0 or 3 -> N_UNI.
- FSM states: IDLE -> SYNC -> RUN -> DONE -> IDLE.
  - SYNC: exactly 1 cycle; sync=1; cont_32=0, cont17=0; busy=1.
  - RUN: cont_32 increments every cycle and wraps 31->0. enable_cont_32=1 exactly when cont_32==31.
    - On that cycle cont17 increments, unless cont17==len-1, in which case next state is DONE.
  - DONE: 1 cycle; busy<=0, done_flag<=1; counters cleared to 0.
- Latency: start write at edge N -> sync high in cycle N+1 -> cont_32=0 first RUN cycle at N+2. Total busy duration = 1 + 32*len + 1 cycles.
- Data-phase direction is decided per frame:
  - READ: cmd 1, or cmd 2 with cont17>=7.
  - WRITE: cmd 0, cmd 3, or cmd 2 with cont17<7.
- Strobe windows in RUN, by cont_32 value (all outputs registered; window is inclusive):
  - CS_n low 2..29.
  - AD_n low 2..9.
  - WR_n low 4..8 (address write).
  - WRITE frame: WR_n additionally low 16..22.
  - READ frame: RD_n low 20..28, covering the mux sampling window 24..28.
  - Outside RUN, all strobes are high.
- LE: 1 when state==RUN && cmd_q==2 && cont17>=8; otherwise 0.
- Invariants: RD_n and WR_n are never low simultaneously; AD_n low only while CS_n low.
- estado is driven combinationally from busy and done_flag; it does not decode port_id.

Decomposition:
- Shared package holds:
  - command encodings CMD_INIT=0, CMD_LEC=1, CMD_ESC=2, CMD_MOD=3;
  - FSM state encoding;
  - strobe window constants (CS, AD, WR_ADDR, WR_DATA, RD bounds);
  - first read-back frame index (7) and LE frame index (8).
- One sub-module is natural: rtc_strobe_gen. It is purely registered decode of (cont_32, frame-is-read, run) into the four strobes.
- The FSM and counters stay in the top module.

Test Plan:
- Reset mid-RUN with cont_32=22 in a WRITE frame -> CS_n, AD_n, WR_n, RD_n all 1 asynchronously; estado=8'h00; after release, FSM is IDLE.
- Write port 0x11 with 8'h01 -> sync high 1 cycle; 10 enable_cont_32 pulses spaced 32 cycles apart; cont17 counts 0..9; RD_n low at cont_32 20..28 every frame; WR_n never low in 16..22; estado goes 8'h01 -> 8'h02 after 322 cycles.
- cmd 8'h02 -> 17 frames; WR_n data pulse only in frames 0..6; RD_n pulse in frames 7..16; LE=1 only in frames 8..16.
- Start (port 0x11, 8'h03) issued while busy during a READ burst -> ignored; burst completes with 10 frames; cmd_q stays 1.
- cmd 8'h00 -> exactly one frame: AD_n low 2..9, WR_n low 4..8 and 16..22, then DONE; done_flag=1 until the next start.
- Write to port 0x10 with en_01=1 -> no state change; estado unchanged.
